// File: rtl/adr_fetch_pkg.sv
// Shared widths, PC stride and fetch-buffer entry type for the instruction-fetch slice.
// Defaults mirror the legacy ADR_ADDRESS_LEN / ADR_INST_LEN width macros.
package adr_fetch_pkg;

    localparam int unsigned ADR_ADDRESS_LEN = 32;
    localparam int unsigned ADR_INST_LEN    = 32;
    localparam int unsigned PC_STEP         = 4;

    typedef struct packed {
        logic [ADR_ADDRESS_LEN-1:0] pc;
        logic [ADR_INST_LEN-1:0]    inst;
    } fetch_entry_t;

endpackage

// File: rtl/adr_fetch_unit_if.sv
// Bundles the icache request/response and decode handshake of the fetch unit.
// master = fetch unit side, slave = icache/decode side.
interface adr_fetch_unit_if #(
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned INST_LEN    = 32
);

    logic                   icache_req_o;
    logic [ADDRESS_LEN-1:0] icache_addr_o;
    logic [INST_LEN-1:0]    icache_data_i;
    logic                   inst_valid_o;
    logic [INST_LEN-1:0]    inst_o;
    logic [ADDRESS_LEN-1:0] inst_pc_o;
    logic                   inst_ready_i;

    modport master (
        output icache_req_o,
        output icache_addr_o,
        input  icache_data_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  icache_req_o,
        input  icache_addr_o,
        output icache_data_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o,
        output inst_ready_i
    );

endinterface

// File: rtl/adr_fetch_fifo.sv
// Synchronous fetch buffer with flush and occupancy count.
// No bypass: a push into an empty buffer becomes visible on the following cycle.
module adr_fetch_fifo
    import adr_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = ADR_ADDRESS_LEN + ADR_INST_LEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed through the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/adr_fetch_unit.sv
// Instruction-fetch initiator: PC register, one-deep in-flight stage for the
// single-cycle icache, credit-gated issue and a fetch buffer toward decode.
module adr_fetch_unit
    import adr_fetch_pkg::*;
#(
    parameter int unsigned             ADDRESS_LEN = ADR_ADDRESS_LEN,
    parameter int unsigned             INST_LEN    = ADR_INST_LEN,
    parameter logic [ADDRESS_LEN-1:0]  RESET_PC    = '0,
    parameter int unsigned             FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    adr_fetch_unit_if.master       bus,
    input  logic                   redirect_i,
    input  logic [ADDRESS_LEN-1:0] redirect_pc_i
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDRESS_LEN + INST_LEN;

    typedef struct packed {
        logic [ADDRESS_LEN-1:0] pc;
        logic [INST_LEN-1:0]    inst;
    } entry_t;

    logic [ADDRESS_LEN-1:0] pc_q, pc_d;
    logic [ADDRESS_LEN-1:0] inflight_pc_q, inflight_pc_d;
    logic                   inflight_q, inflight_d;

    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W:0]         credit_used;
    entry_t                 push_entry;
    entry_t                 head_entry;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Buffered entries plus the outstanding fetch must never exceed the buffer.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
    assign issue       = !reset && !redirect_i && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign push        = inflight_q && !redirect_i;
    assign pop         = !fifo_empty && bus.inst_ready_i && !redirect_i;

    assign push_entry.pc   = inflight_pc_q;
    assign push_entry.inst = bus.icache_data_i;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[ADDRESS_LEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d          = pc_q + ADDRESS_LEN'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    adr_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head_entry),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign bus.icache_req_o  = issue;
    assign bus.icache_addr_o = pc_q;
    assign bus.inst_valid_o  = !fifo_empty;
    assign bus.inst_o        = fifo_empty ? '0 : head_entry.inst;
    assign bus.inst_pc_o     = fifo_empty ? '0 : head_entry.pc;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full))
        else $error("fetch buffer push while full");
`endif

endmodule

// File: tb/tb_adr_fetch_unit.sv
// Self-checking bench for adr_fetch_unit: directed vector table, hand-written
// redirect/reset sequences and a randomized run against a transaction-level model.
module tb_adr_fetch_unit;
    import adr_fetch_pkg::*;

    localparam int unsigned AL    = 32;
    localparam int unsigned IL    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    adr_fetch_unit_if #(.ADDRESS_LEN(AL), .INST_LEN(IL)) bus ();

    adr_fetch_unit #(
        .ADDRESS_LEN (AL),
        .INST_LEN    (IL),
        .RESET_PC    (32'h0),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    always #5 clk = ~clk;

    // Icache model: one-cycle latency, word derived from the address.
    always @(posedge clk)
        bus.icache_data_i <= bus.icache_req_o ? (bus.icache_addr_o ^ KEY) : 32'hDEAD_BEEF;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } pend_t;
    pend_t       q[$];
    logic [31:0] issue_pc = '0;

    typedef struct {
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_req();
        return !redirect && (q.size() < DEPTH);
    endfunction

    function automatic bit model_valid();
        return (q.size() > 0) && (q[0].cyc <= cyc - 2);
    endfunction

    task automatic model_check();
        bit er, ev;
        er = model_req();
        ev = model_valid();
        check("req", bus.icache_req_o, er);
        if (er) check("addr", bus.icache_addr_o, issue_pc);
        check("valid", bus.inst_valid_o, ev);
        if (ev) begin
            check("head_pc", bus.inst_pc_o, q[0].pc);
            check("head_inst", bus.inst_o, q[0].pc ^ KEY);
        end
    endtask

    task automatic model_update();
        bit er, ev;
        er = model_req();
        ev = model_valid();
        if (redirect) begin
            q.delete();
            issue_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (ev && bus.inst_ready_i) void'(q.pop_front());
            if (er) begin
                q.push_back('{pc: issue_pc, cyc: cyc});
                issue_pc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        issue_pc = 32'h0;
        cyc      = 0;
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain_expect(input logic [31:0] start, input int n, input int budget);
        logic [31:0] exp;
        int          got;
        exp = start;
        got = 0;
        bus.inst_ready_i = 1'b1;
        redirect = 1'b0;
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            if (bus.inst_valid_o) begin
                check("drain_pc", bus.inst_pc_o, exp);
                check("drain_inst", bus.inst_o, exp ^ KEY);
                exp += 32'd4;
                got++;
            end
            finish_cycle();
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 1, 32'h04, 0, 32'h00};
        tbl[2]  = '{0, 1, 32'h08, 1, 32'h00};
        tbl[3]  = '{0, 1, 32'h0C, 1, 32'h00};
        for (int i = 4; i < 10; i++) tbl[i] = '{0, 0, 32'h00, 1, 32'h00};
        tbl[10] = '{1, 0, 32'h00, 1, 32'h00};
        tbl[11] = '{1, 1, 32'h10, 1, 32'h04};
        tbl[12] = '{1, 1, 32'h14, 1, 32'h08};
        tbl[13] = '{1, 1, 32'h18, 1, 32'h0C};
        tbl[14] = '{1, 1, 32'h1C, 1, 32'h10};
        tbl[15] = '{1, 1, 32'h20, 1, 32'h14};

        bus.inst_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", bus.icache_req_o, 0);
        check("rst_valid", bus.inst_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_pc", bus.inst_pc_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Streaming from reset, decode always ready
        bus.inst_ready_i = 1'b1;
        @(negedge clk);
        check("s_c0_req", bus.icache_req_o, 1);
        check("s_c0_addr", bus.icache_addr_o, 32'h0);
        check("s_c0_valid", bus.inst_valid_o, 0);
        finish_cycle();
        @(negedge clk);
        check("s_c1_valid", bus.inst_valid_o, 0);
        check("s_c1_addr", bus.icache_addr_o, 32'h4);
        finish_cycle();
        @(negedge clk);
        check("s_c2_valid", bus.inst_valid_o, 1);
        check("s_c2_pc", bus.inst_pc_o, 32'h0);
        finish_cycle();
        drain_expect(32'h4, 6, 10);

        // Backpressure table: ready low for 10 cycles, then released
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.inst_ready_i = tbl[i].ready;
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), bus.icache_req_o, tbl[i].exp_req);
            if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), bus.icache_addr_o, tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), bus.inst_valid_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_pc", i), bus.inst_pc_o, tbl[i].exp_pc);
                check($sformatf("tbl%0d_inst", i), bus.inst_o, tbl[i].exp_pc ^ KEY);
            end
            finish_cycle();
        end
        drain_expect(32'h18, 4, 10);

        // Redirect with 3 buffered entries and 1 in flight
        do_reset();
        bus.inst_ready_i = 1'b0;
        repeat (4) cycle();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        check("rd_n_req", bus.icache_req_o, 0);
        finish_cycle();
        redirect = 1'b0;
        bus.inst_ready_i = 1'b1;
        @(negedge clk);
        check("rd_n1_valid", bus.inst_valid_o, 0);
        check("rd_n1_req", bus.icache_req_o, 1);
        check("rd_n1_addr", bus.icache_addr_o, 32'h100);
        finish_cycle();
        @(negedge clk);
        check("rd_n2_valid", bus.inst_valid_o, 0);
        finish_cycle();
        @(negedge clk);
        check("rd_n3_valid", bus.inst_valid_o, 1);
        check("rd_n3_pc", bus.inst_pc_o, 32'h100);
        finish_cycle();
        drain_expect(32'h104, 4, 8);

        // Back-to-back redirects: last one wins
        redirect = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        redirect_pc = 32'h300;
        cycle();
        drain_expect(32'h300, 5, 12);

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        drain_expect(32'hFFFF_FFF8, 4, 10);

        // Reset mid-stream with two entries queued
        do_reset();
        bus.inst_ready_i = 1'b0;
        repeat (3) cycle();
        #2;
        reset = 1'b1;
        #1;
        check("mr_valid", bus.inst_valid_o, 0);
        check("mr_req", bus.icache_req_o, 0);
        check("mr_inst", bus.inst_o, 0);
        check("mr_pc", bus.inst_pc_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drain_expect(32'h0, 4, 10);

        // Unaligned redirect target
        redirect = 1'b1;
        redirect_pc = 32'h103;
        cycle();
        drain_expect(32'h100, 4, 10);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.inst_ready_i = ($urandom_range(0, 9) < 6);
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else redirect_pc = $urandom;
            cycle();
        end
        redirect = 1'b0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
